// File: rtl/fnn_input_sequencer.sv
// fnn_input_sequencer: streams stored image pixels into a feed-forward network one at a time,
// then scores each returned classification against the label of the image's class block.
`default_nettype none

module fnn_input_sequencer #(
   parameter int INDATA_WIDTH     = 16,
   parameter int NO_OF_INPUTS     = 784,
   parameter int NO_OF_IMAGES     = 140,
   parameter int IMAGES_PER_CLASS = 20,
   parameter int ADDR_WIDTH       = 17
) (
   input  logic                    clk,
   input  logic                    restart,
   input  logic                    start,
   output logic                    mem_rd_en,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   input  logic [INDATA_WIDTH-1:0] mem_rdata,
   input  logic                    FNN_ready,
   input  logic                    FNN_ready_to_accept,
   output logic                    start_FNN,
   output logic                    ready_in,
   output logic [INDATA_WIDTH-1:0] input_image,
   input  logic [3:0]              max,
   input  logic                    finish_FNN,
   output logic                    fnn_restart,
   output logic [7:0]              no_of_images,
   output logic [7:0]              correctly_identified,
   output logic                    done
);

   localparam int CLS_W = (IMAGES_PER_CLASS > 1) ? $clog2(IMAGES_PER_CLASS) : 1;

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_WAIT_READY  = 3'd1,
      S_FETCH       = 3'd2,
      S_PRESENT     = 3'd3,
      S_WAIT_RESULT = 3'd4,
      S_SCORE       = 3'd5,
      S_DONE        = 3'd6
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic [ADDR_WIDTH-1:0]   pix_q, pix_d;
   logic [INDATA_WIDTH-1:0] img_q, img_d;
   logic                    first_q, first_d;
   logic [3:0]              max_q, max_d;
   logic [7:0]              nimg_q, nimg_d;
   logic [7:0]              ncorr_q, ncorr_d;
   logic [7:0]              label_q, label_d;
   logic [CLS_W-1:0]        cls_q, cls_d;

   assign no_of_images         = nimg_q;
   assign correctly_identified = ncorr_q;

   // Read data arrives during the first PRESENT cycle, so it is passed straight through
   // then and held from the register for the rest of the stall.
   assign input_image = first_q ? mem_rdata : img_q;

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      pix_d       = pix_q;
      img_d       = first_q ? mem_rdata : img_q;
      first_d     = 1'b0;
      max_d       = max_q;
      nimg_d      = nimg_q;
      ncorr_d     = ncorr_q;
      label_d     = label_q;
      cls_d       = cls_q;
      mem_rd_en   = 1'b0;
      mem_addr    = '0;
      start_FNN   = 1'b0;
      ready_in    = 1'b0;
      fnn_restart = 1'b0;
      done        = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            done = (state_q == S_DONE);
            if (start) begin
               nimg_d  = '0;
               ncorr_d = '0;
               label_d = '0;
               cls_d   = '0;
               base_d  = '0;
               pix_d   = '0;
               state_d = S_WAIT_READY;
            end
         end
         S_WAIT_READY: begin
            if (FNN_ready) state_d = S_FETCH;
         end
         S_FETCH: begin
            start_FNN = 1'b1;
            mem_rd_en = 1'b1;
            mem_addr  = base_q + pix_q;
            first_d   = 1'b1;
            state_d   = S_PRESENT;
         end
         S_PRESENT: begin
            start_FNN = 1'b1;
            ready_in  = 1'b1;
            if (FNN_ready_to_accept) begin
               pix_d   = pix_q + 1'b1;
               state_d = (32'(pix_d) < 32'(NO_OF_INPUTS)) ? S_FETCH : S_WAIT_RESULT;
            end
         end
         S_WAIT_RESULT: begin
            start_FNN = 1'b1;
            if (finish_FNN) begin
               max_d   = max;
               state_d = S_SCORE;
            end
         end
         S_SCORE: begin
            start_FNN   = 1'b1;
            fnn_restart = 1'b1;
            if (nimg_q != 8'hFF) nimg_d = nimg_q + 1'b1;
            if (max_q <= 4'd9 && {4'd0, max_q} == label_q && ncorr_q != 8'hFF)
               ncorr_d = ncorr_q + 1'b1;
            base_d = base_q + ADDR_WIDTH'(NO_OF_INPUTS);
            pix_d  = '0;
            if (32'(cls_q) == 32'(IMAGES_PER_CLASS - 1)) begin
               cls_d = '0;
               if (label_q != 8'hFF) label_d = label_q + 1'b1;
            end else begin
               cls_d = cls_q + 1'b1;
            end
            state_d = (32'(nimg_d) == 32'(NO_OF_IMAGES)) ? S_DONE : S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge restart) begin
      if (restart) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         pix_q   <= '0;
         img_q   <= '0;
         first_q <= 1'b0;
         max_q   <= '0;
         nimg_q  <= '0;
         ncorr_q <= '0;
         label_q <= '0;
         cls_q   <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         pix_q   <= pix_d;
         img_q   <= img_d;
         first_q <= first_d;
         max_q   <= max_d;
         nimg_q  <= nimg_d;
         ncorr_q <= ncorr_d;
         label_q <= label_d;
         cls_q   <= cls_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fnn_input_sequencer.sv
// tb_fnn_input_sequencer: directed runs checked every cycle against an event-level model.
`default_nettype none

module tb_fnn_input_sequencer;

   localparam int NI   = 8;
   localparam int NIMG = 6;
   localparam int IPC  = 2;
   localparam int DW   = 16;
   localparam int AW   = 17;

   logic          clk = 1'b0;
   logic          restart, start, FNN_ready, accept, finish, fnn_restart;
   logic          mem_rd_en, start_FNN, ready_in, done;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata = '0;
   logic [DW-1:0] input_image;
   logic [3:0]    max_in;
   logic [7:0]    no_of_images, correctly_identified;

   int total = 0;
   int bad   = 0;

   fnn_input_sequencer #(
      .INDATA_WIDTH(DW), .NO_OF_INPUTS(NI), .NO_OF_IMAGES(NIMG),
      .IMAGES_PER_CLASS(IPC), .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .restart(restart), .start(start),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .FNN_ready(FNN_ready), .FNN_ready_to_accept(accept),
      .start_FNN(start_FNN), .ready_in(ready_in), .input_image(input_image),
      .max(max_in), .finish_FNN(finish), .fnn_restart(fnn_restart),
      .no_of_images(no_of_images), .correctly_identified(correctly_identified),
      .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] pix_data(input int a);
      return DW'((a * 59) ^ 32'h5a5a);
   endfunction

   always @(posedge clk) if (mem_rd_en) mem_rdata <= pix_data(int'(mem_addr));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Event-level model of one run
   bit       m_run, m_wr, m_waitres, m_pend, m_presenting, m_done;
   int       m_cnt, m_pix, m_img, m_correct, m_xfers, n_restart;
   int       m_max;
   int       first_addr [8];

   always @(negedge clk) begin
      if (restart) begin
         check("rst_rd_en", mem_rd_en, 0);
         check("rst_addr", mem_addr, 0);
         check("rst_ready_in", ready_in, 0);
         check("rst_image", input_image, 0);
         check("rst_start_fnn", start_FNN, 0);
         check("rst_fnn_restart", fnn_restart, 0);
         check("rst_nimg", no_of_images, 0);
         check("rst_ncorr", correctly_identified, 0);
         check("rst_done", done, 0);
         m_run = 0; m_wr = 0; m_waitres = 0; m_pend = 0; m_presenting = 0; m_done = 0;
         m_cnt = 0; m_pix = 0; m_img = 0; m_correct = 0;
      end else begin
         if (m_cnt > 0) m_cnt--;
         if (m_pend && m_cnt == 0) begin
            if (m_max <= 9 && m_max == m_img / IPC && m_correct < 255) m_correct++;
            if (m_img < 255) m_img++;
            m_pix = 0; m_waitres = 0; m_pend = 0;
            if (m_img == NIMG) begin m_done = 1; m_run = 0; end
         end
         check("nimg", no_of_images, m_img);
         check("ncorr", correctly_identified, m_correct);
         check("done", done, m_done);
         check("start_fnn", start_FNN, m_run && !m_wr);
         check("fnn_restart", fnn_restart, m_pend && m_cnt == 1);
         if (fnn_restart) n_restart++;
         if (mem_rd_en) begin
            check("fetch_allowed", m_run && !m_wr && !m_waitres && !m_pend && !m_presenting, 1);
            check("mem_addr", mem_addr, m_img * NI + m_pix);
            if (m_pix == 0 && m_img < 8) first_addr[m_img] = int'(mem_addr);
            m_presenting = 1;
         end
         if (ready_in) begin
            check("present_allowed", m_presenting, 1);
            check("input_image", input_image, pix_data(m_img * NI + m_pix));
         end
         if (!m_run && start) begin
            m_run = 1; m_wr = 1; m_done = 0; m_img = 0; m_correct = 0; m_pix = 0;
            m_waitres = 0; m_pend = 0; m_presenting = 0;
         end else if (m_run && m_wr && FNN_ready) begin
            m_wr = 0;
         end
         if (m_waitres && !m_pend && finish) begin
            m_pend = 1; m_cnt = 2; m_max = int'(max_in);
         end
         if (ready_in && accept) begin
            m_pix++; m_xfers++; m_presenting = 0;
            if (m_pix == NI) m_waitres = 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic give_result(input int i, input logic [3:0] mx);
      bit ok = 0;
      for (int k = 0; k < 400; k++) begin
         tick();
         if (m_waitres && !m_pend && m_img == i) begin ok = 1; break; end
      end
      check("wait_result_timeout", ok, 1);
      tick(); tick();
      finish = 1; max_in = mx;
      tick();
      finish = 0; max_in = 4'd0;
   endtask

   task automatic wait_present(input int img, input int pix);
      bit ok = 0;
      for (int k = 0; k < 400; k++) begin
         tick();
         if (ready_in && m_img == img && m_pix == pix) begin ok = 1; break; end
      end
      check("wait_present_timeout", ok, 1);
   endtask

   logic [3:0] tbl [NIMG];
   int         rd_cnt;
   bit         ok;

   initial begin
      tbl = '{4'd0, 4'd3, 4'd1, 4'd15, 4'd2, 4'd2};
      restart = 1; start = 0; FNN_ready = 0; accept = 1; finish = 0; max_in = 0;
      n_restart = 0; m_xfers = 0;
      repeat (3) tick();
      restart = 0;
      repeat (3) tick();

      // Run 1: FNN_ready held off briefly, then full run of NIMG images
      start = 1; tick(); start = 0;
      repeat (3) tick();
      FNN_ready = 1;
      for (int i = 0; i < NIMG; i++) begin
         if (i == 0) begin
            wait_present(0, 0);
            finish = 1; start = 1;
            tick();
            finish = 0; start = 0;
         end
         if (i == 1) begin
            wait_present(1, 3);
            accept = 0; rd_cnt = 0;
            for (int k = 0; k < 10; k++) begin
               tick();
               check("stall_ready_in", ready_in, 1);
               check("stall_image", input_image, pix_data(NI + 3));
               if (mem_rd_en) rd_cnt++;
            end
            check("stall_no_fetch", rd_cnt, 0);
            accept = 1;
         end
         give_result(i, tbl[i]);
      end
      ok = 0;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (done) begin ok = 1; break; end
      end
      check("done_timeout", ok, 1);
      check("run1_nimg", no_of_images, 6);
      check("run1_ncorr", correctly_identified, 4);
      check("run1_restarts", n_restart, 6);
      check("run1_xfers", m_xfers, 48);
      check("run1_img1_addr", first_addr[1], 8);
      check("run1_img5_addr", first_addr[5], 40);
      repeat (5) tick();
      check("done_hold", done, 1);
      check("done_hold_nimg", no_of_images, 6);

      // Run 2: restart partway through image 2
      start = 1; tick(); start = 0;
      give_result(0, 4'd0);
      give_result(1, 4'd1);
      wait_present(2, 4);
      restart = 1;
      tick();
      restart = 0;
      rd_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (mem_rd_en) rd_cnt++;
      end
      check("idle_after_restart", rd_cnt, 0);
      check("nimg_after_restart", no_of_images, 0);
      start = 1; tick(); start = 0;
      ok = 0;
      for (int k = 0; k < 20; k++) begin
         if (mem_rd_en) begin ok = 1; break; end
         tick();
      end
      check("refetch_timeout", ok, 1);
      check("refetch_addr", mem_addr, 0);
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
